seq_divider_8bit: RTL

SEQ_DIVIDER_8BIT -- requirements
Module: seq_divider_8bit

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 25 ++
 rtl/seq_divider_8bit.sv | 119 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the 8-bit sequential divider: operand widths and
// the controller state encoding.
package div_pkg;

  localparam int DIVIDEND_W_C = 8;
  localparam int DIVISOR_W_C  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step
  import div_pkg::*;
#(
  parameter int DIVISOR_W = DIVISOR_W_C
) (
  input  logic [DIVISOR_W:0]   rem,
  input  logic                 dividend_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_next,
  output logic                 quotient_bit
);

  // The partial remainder is always below the divisor, but the shift is kept
  // one bit wider so the compare never loses a carry.
  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W:0]   diff;

  assign shifted      = {rem, dividend_bit};
  assign quotient_bit = (shifted >= {2'b00, divisor});
  assign diff         = shifted[DIVISOR_W:0] - {1'b0, divisor};
  assign rem_next     = quotient_bit ? diff : shifted[DIVISOR_W:0];

endmodule : div_step

// File: rtl/seq_divider_8bit.sv
// Sequential unsigned divider: 8-bit dividend by 5-bit divisor, one restoring
// step per clock, MSB first. A zero divisor short-circuits to a saturated
// quotient with div_by_zero set.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE, out_valid only in DONE; once out_valid
// is 1 the result holds steady until out_ready takes it, and in_ready comes
// back the cycle after that transfer.
module seq_divider_8bit
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_C,
  parameter int DIVISOR_W  = DIVISOR_W_C
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output div_state_e            dbg_state
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIVIDEND_W - 1);

  div_state_e            state;
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [DIVIDEND_W-1:0] quo_q;
  logic [DIVISOR_W:0]    rem_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [DIVISOR_W:0]    step_rem;
  logic                  step_bit;

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem          (rem_q),
    .dividend_bit (dvd_q[DIVIDEND_W-1]),
    .divisor      (dvs_q),
    .rem_next     (step_rem),
    .quotient_bit (step_bit)
  );

  // The partial remainder never reaches the divisor, so its low bits are the
  // final remainder once the loop has finished.
  assign quotient  = quo_q;
  assign remainder = rem_q[DIVISOR_W-1:0];
  assign dbg_state = state;

  // Controller, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            dvd_q    <= dividend;
            dvs_q    <= divisor;
            rem_q    <= '0;
            if (divisor == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              div_by_zero <= 1'b1;
              quo_q       <= '1;
              cnt_q       <= '0;
            end else begin
              state       <= CALC;
              div_by_zero <= 1'b0;
              quo_q       <= '0;
              cnt_q       <= CNT_LOAD;
            end
          end
        end
        CALC: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[DIVIDEND_W-2:0], step_bit};
          dvd_q <= {dvd_q[DIVIDEND_W-2:0], 1'b0};
          if (cnt_q == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule : seq_divider_8bit
